// File: rtl/jtag_tap_pkg.sv
// Shared definitions for the JTAG TAP responder: TAP state encodings,
// default instruction opcodes and the default IDCODE value.
package jtag_tap_pkg;

  localparam int          IR_W_DEF      = 5;
  localparam logic [31:0] IDCODE_DEF    = 32'hDEB1_1001;
  localparam logic [4:0]  OP_IDCODE_DEF = 5'h01;
  localparam logic [4:0]  OP_USER_DEF   = 5'h10;

  // Conventional 1149.1 4-bit state codes, visible on tap_state.
  typedef enum logic [3:0] {
    TAP_EX2DR = 4'h0,
    TAP_EX1DR = 4'h1,
    TAP_SHDR  = 4'h2,
    TAP_PAUDR = 4'h3,
    TAP_SELIR = 4'h4,
    TAP_UPDDR = 4'h5,
    TAP_CAPDR = 4'h6,
    TAP_SELDR = 4'h7,
    TAP_EX2IR = 4'h8,
    TAP_EX1IR = 4'h9,
    TAP_SHIR  = 4'hA,
    TAP_PAUIR = 4'hB,
    TAP_RTI   = 4'hC,
    TAP_UPDIR = 4'hD,
    TAP_CAPIR = 4'hE,
    TAP_TLR   = 4'hF
  } tap_state_e;

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchroniser followed by an edge-detect register. The
// registered rise/fall pulses and o_sync all come out of the same stage,
// so a data pin synchronised by another instance lines up with the
// clock edge reported here (pulse 3 mclk after the pin edge).
module jtag_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  // Metastability filter: two back-to-back flops on the asynchronous pin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  // Edge detection with registered one-cycle pulses, aligned with o_sync.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_sync = r_prev;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/jtag_tap_slave.sv
// IEEE 1149.1 TAP controller oversampled on mclk. Provides IDCODE, BYPASS
// and a 32-bit USER data register with core capture/update.
// Optional feature macro: JTAG_TAP_TRST_EN adds a synchronised i_trst_n
// that holds the TAP in Test-Logic-Reset with IR=OP_IDCODE while low.
module jtag_tap_slave
  import jtag_tap_pkg::*;
#(
  parameter int                IR_W      = IR_W_DEF,
  parameter logic [31:0]       IDCODE    = IDCODE_DEF,
  parameter logic [IR_W-1:0]   OP_IDCODE = IR_W'(OP_IDCODE_DEF),
  parameter logic [IR_W-1:0]   OP_USER   = IR_W'(OP_USER_DEF)
) (
  input  logic        i_mclk,
  input  logic        i_reset_n,
  input  logic        i_tck,
  input  logic        i_tms,
  input  logic        i_tdi,
`ifdef JTAG_TAP_TRST_EN
  input  logic        i_trst_n,
`endif
  output logic        o_tdo,
  output logic        o_tdo_oe,
  output logic [3:0]  o_tap_state,
  input  logic [31:0] i_user_cap_data,
  output logic [31:0] o_user_upd_data,
  output logic        o_user_upd_stb
);

  logic w_tck_sync, w_tck_rise, w_tck_fall;
  logic w_tms, w_tms_rise, w_tms_fall;
  logic w_tdi, w_tdi_rise, w_tdi_fall;
  logic w_trst_ok;
  logic w_rise;
  logic w_sel_id, w_sel_user, w_sel_dr32;
  logic w_unused;

  tap_state_e      r_state;
  tap_state_e      w_next;
  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] r_ir_sr;
  logic [31:0]     r_dr_sr;
  logic            r_byp;
  logic            r_tdo;
  logic            r_tdo_oe;
  logic [31:0]     r_upd;
  logic            r_stb;

  jtag_sync_edge #(.RST_VAL(1'b0)) u_sync_tck (
    .i_clk(i_mclk), .i_rst_n(i_reset_n), .i_async(i_tck),
    .o_sync(w_tck_sync), .o_rise(w_tck_rise), .o_fall(w_tck_fall));

  jtag_sync_edge #(.RST_VAL(1'b1)) u_sync_tms (
    .i_clk(i_mclk), .i_rst_n(i_reset_n), .i_async(i_tms),
    .o_sync(w_tms), .o_rise(w_tms_rise), .o_fall(w_tms_fall));

  jtag_sync_edge #(.RST_VAL(1'b0)) u_sync_tdi (
    .i_clk(i_mclk), .i_rst_n(i_reset_n), .i_async(i_tdi),
    .o_sync(w_tdi), .o_rise(w_tdi_rise), .o_fall(w_tdi_fall));

`ifdef JTAG_TAP_TRST_EN
  logic w_trst_rise, w_trst_fall;
  jtag_sync_edge #(.RST_VAL(1'b1)) u_sync_trst (
    .i_clk(i_mclk), .i_rst_n(i_reset_n), .i_async(i_trst_n),
    .o_sync(w_trst_ok), .o_rise(w_trst_rise), .o_fall(w_trst_fall));
  assign w_unused = ^{w_tck_sync, w_tms_rise, w_tms_fall, w_tdi_rise, w_tdi_fall,
                      w_trst_rise, w_trst_fall};
`else
  assign w_trst_ok = 1'b1;
  assign w_unused  = ^{w_tck_sync, w_tms_rise, w_tms_fall, w_tdi_rise, w_tdi_fall};
`endif

  // A tck rise only counts while the TAP is not held in reset by trst.
  assign w_rise     = w_tck_rise & w_trst_ok;
  assign w_sel_id   = (r_ir == OP_IDCODE);
  assign w_sel_user = (r_ir == OP_USER);
  assign w_sel_dr32 = w_sel_id | w_sel_user;

  // TAP state register; trst forces Test-Logic-Reset.
  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= TAP_TLR;
    end else if (!w_trst_ok) begin
      r_state <= TAP_TLR;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode of the 1149.1 TMS table, evaluated on tck rise only.
  always_comb begin
    w_next = r_state;
    if (w_rise) begin
      case (r_state)
        TAP_TLR:   w_next = w_tms ? TAP_TLR   : TAP_RTI;
        TAP_RTI:   w_next = w_tms ? TAP_SELDR : TAP_RTI;
        TAP_SELDR: w_next = w_tms ? TAP_SELIR : TAP_CAPDR;
        TAP_CAPDR: w_next = w_tms ? TAP_EX1DR : TAP_SHDR;
        TAP_SHDR:  w_next = w_tms ? TAP_EX1DR : TAP_SHDR;
        TAP_EX1DR: w_next = w_tms ? TAP_UPDDR : TAP_PAUDR;
        TAP_PAUDR: w_next = w_tms ? TAP_EX2DR : TAP_PAUDR;
        TAP_EX2DR: w_next = w_tms ? TAP_UPDDR : TAP_SHDR;
        TAP_UPDDR: w_next = w_tms ? TAP_SELDR : TAP_RTI;
        TAP_SELIR: w_next = w_tms ? TAP_TLR   : TAP_CAPIR;
        TAP_CAPIR: w_next = w_tms ? TAP_EX1IR : TAP_SHIR;
        TAP_SHIR:  w_next = w_tms ? TAP_EX1IR : TAP_SHIR;
        TAP_EX1IR: w_next = w_tms ? TAP_UPDIR : TAP_PAUIR;
        TAP_PAUIR: w_next = w_tms ? TAP_EX2IR : TAP_PAUIR;
        TAP_EX2IR: w_next = w_tms ? TAP_UPDIR : TAP_SHIR;
        TAP_UPDIR: w_next = w_tms ? TAP_SELDR : TAP_RTI;
        default:   w_next = TAP_TLR;
      endcase
    end else begin
      w_next = r_state;
    end
  end

  // IR shift register: capture the fixed 01 pattern, shift tdi in at MSB.
  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ir_sr <= '0;
    end else if (w_rise) begin
      case (r_state)
        TAP_CAPIR: r_ir_sr <= IR_W'(2'b01);
        TAP_SHIR:  r_ir_sr <= {w_tdi, r_ir_sr[IR_W-1:1]};
        default:   r_ir_sr <= r_ir_sr;
      endcase
    end
  end

  // Instruction register: load on entry to Update-IR, forced in TLR / trst.
  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ir <= OP_IDCODE;
    end else if (!w_trst_ok || (r_state == TAP_TLR)) begin
      r_ir <= OP_IDCODE;
    end else if (w_rise && (w_next == TAP_UPDIR)) begin
      r_ir <= r_ir_sr;
    end
  end

  // Data registers: 32-bit shifter shared by IDCODE/USER, 1-bit bypass stage.
  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dr_sr <= 32'h0;
      r_byp   <= 1'b0;
    end else if (w_rise) begin
      case (r_state)
        TAP_CAPDR: begin
          if (w_sel_id) begin
            r_dr_sr <= IDCODE;
          end else if (w_sel_user) begin
            r_dr_sr <= i_user_cap_data;
          end else begin
            r_byp <= 1'b0;
          end
        end
        TAP_SHDR: begin
          if (w_sel_dr32) begin
            r_dr_sr <= {w_tdi, r_dr_sr[31:1]};
          end else begin
            r_byp <= w_tdi;
          end
        end
        default: r_byp <= r_byp;
      endcase
    end
  end

  // USER update: latch the shifter and strobe once on entry to Update-DR.
  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_upd <= 32'h0;
      r_stb <= 1'b0;
    end else if (w_rise && (w_next == TAP_UPDDR) && w_sel_user) begin
      r_upd <= r_dr_sr;
      r_stb <= 1'b1;
    end else begin
      r_stb <= 1'b0;
    end
  end

  // tdo/tdo_oe change on tck fall; tdo holds its value outside shift states.
  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else if (w_tck_fall) begin
      case (r_state)
        TAP_SHIR: begin
          r_tdo    <= r_ir_sr[0];
          r_tdo_oe <= 1'b1;
        end
        TAP_SHDR: begin
          r_tdo    <= w_sel_dr32 ? r_dr_sr[0] : r_byp;
          r_tdo_oe <= 1'b1;
        end
        default: r_tdo_oe <= 1'b0;
      endcase
    end
  end

  assign o_tdo           = r_tdo;
  assign o_tdo_oe        = r_tdo_oe;
  assign o_tap_state     = r_state;
  assign o_user_upd_data = r_upd;
  assign o_user_upd_stb  = r_stb;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Self-checking bench for jtag_tap_slave: directed JTAG sequences plus
// randomised scans, compared every tck cycle against a behavioural TAP
// model (table lookup for states, integers/queues for the registers).
module tb_jtag_tap_slave;
  import jtag_tap_pkg::*;

  logic        mclk = 1'b0;
  logic        rst_n, tck, tms, tdi;
  logic        tdo, tdo_oe, stb;
  logic [3:0]  tap_state;
  logic [31:0] cap, upd;
`ifdef JTAG_TAP_TRST_EN
  logic        trst_n;
`endif

  jtag_tap_slave dut (
    .i_mclk(mclk), .i_reset_n(rst_n), .i_tck(tck), .i_tms(tms), .i_tdi(tdi),
`ifdef JTAG_TAP_TRST_EN
    .i_trst_n(trst_n),
`endif
    .o_tdo(tdo), .o_tdo_oe(tdo_oe), .o_tap_state(tap_state),
    .i_user_cap_data(cap), .o_user_upd_data(upd), .o_user_upd_stb(stb));

  always #5 mclk = ~mclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  nt0 [16];
  logic [3:0]  nt1 [16];
  logic [3:0]  m_state;
  int          m_ir, m_ir_sr;
  bit          m_dr_q[$];
  logic        m_tdo, m_oe;
  logic [31:0] m_upd;
  int          m_stb_cnt = 0;

  task automatic set_tr(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    nt0[s] = a;
    nt1[s] = b;
  endtask

  task automatic init_tbl();
    set_tr(TAP_TLR,   TAP_RTI,   TAP_TLR);
    set_tr(TAP_RTI,   TAP_RTI,   TAP_SELDR);
    set_tr(TAP_SELDR, TAP_CAPDR, TAP_SELIR);
    set_tr(TAP_CAPDR, TAP_SHDR,  TAP_EX1DR);
    set_tr(TAP_SHDR,  TAP_SHDR,  TAP_EX1DR);
    set_tr(TAP_EX1DR, TAP_PAUDR, TAP_UPDDR);
    set_tr(TAP_PAUDR, TAP_PAUDR, TAP_EX2DR);
    set_tr(TAP_EX2DR, TAP_SHDR,  TAP_UPDDR);
    set_tr(TAP_UPDDR, TAP_RTI,   TAP_SELDR);
    set_tr(TAP_SELIR, TAP_CAPIR, TAP_TLR);
    set_tr(TAP_CAPIR, TAP_SHIR,  TAP_EX1IR);
    set_tr(TAP_SHIR,  TAP_SHIR,  TAP_EX1IR);
    set_tr(TAP_EX1IR, TAP_PAUIR, TAP_UPDIR);
    set_tr(TAP_PAUIR, TAP_PAUIR, TAP_EX2IR);
    set_tr(TAP_EX2IR, TAP_SHIR,  TAP_UPDIR);
    set_tr(TAP_UPDIR, TAP_RTI,   TAP_SELDR);
  endtask

  task automatic model_reset();
    m_state = TAP_TLR;
    m_ir    = 1;
    m_ir_sr = 0;
    m_dr_q.delete();
    m_tdo   = 1'b0;
    m_oe    = 1'b0;
    m_upd   = 32'h0;
  endtask

  // One full tck period: actions of the state left, transition, then fall.
  task automatic model_step(input logic t_ms, input logic t_di);
    logic [3:0]  nxt;
    logic [31:0] idc;
    nxt = t_ms ? nt1[m_state] : nt0[m_state];
    idc = 32'hDEB1_1001;
    if (m_state == TAP_CAPIR) m_ir_sr = 1;
    else if (m_state == TAP_SHIR) m_ir_sr = (m_ir_sr >> 1) | (int'(t_di) << 4);
    else if (m_state == TAP_CAPDR) begin
      m_dr_q.delete();
      if (m_ir == 1)       for (int i = 0; i < 32; i++) m_dr_q.push_back(idc[i]);
      else if (m_ir == 16) for (int i = 0; i < 32; i++) m_dr_q.push_back(cap[i]);
      else                 m_dr_q.push_back(1'b0);
    end else if (m_state == TAP_SHDR) begin
      void'(m_dr_q.pop_front());
      m_dr_q.push_back(t_di);
    end
    m_state = nxt;
    if (m_state == TAP_UPDIR) m_ir = m_ir_sr;
    if (m_state == TAP_UPDDR && m_ir == 16) begin
      for (int i = 0; i < 32; i++) m_upd[i] = m_dr_q[i];
      m_stb_cnt++;
    end
    if (m_state == TAP_TLR) m_ir = 1;
    if (m_state == TAP_SHIR) begin
      m_tdo = m_ir_sr[0];
      m_oe  = 1'b1;
    end else if (m_state == TAP_SHDR) begin
      m_tdo = m_dr_q[0];
      m_oe  = 1'b1;
    end else begin
      m_oe  = 1'b0;
    end
  endtask

  // ---------------- strobe monitor ----------------
  int   stb_edges = 0;
  int   stb_high  = 0;
  logic stb_prev  = 1'b0;
  always @(negedge mclk) begin
    if (stb === 1'b1) stb_high++;
    if (stb === 1'b1 && stb_prev !== 1'b1) stb_edges++;
    stb_prev = stb;
  end

  // ---------------- compare process ----------------
  event ev_chk;
  always @(ev_chk) begin
    chk("tap_state",  32'(tap_state), 32'(m_state));
    chk("tdo",        32'(tdo),       32'(m_tdo));
    chk("tdo_oe",     32'(tdo_oe),    32'(m_oe));
    chk("upd_data",   upd,            m_upd);
    chk("stb_count",  32'(stb_edges), 32'(m_stb_cnt));
    chk("stb_width",  32'(stb_high),  32'(m_stb_cnt));
  end

  task automatic kick();
    -> ev_chk;
    #1;
  endtask

  // ---------------- JTAG driver ----------------
  task automatic tck_cycle(input logic t_ms, input logic t_di);
    @(negedge mclk);
    tms = t_ms;
    tdi = t_di;
    repeat (2) @(negedge mclk);
    tck = 1'b1;
    repeat (6) @(negedge mclk);
    tck = 1'b0;
    repeat (6) @(negedge mclk);
    model_step(t_ms, t_di);
    kick();
  endtask

  task automatic ir_scan(input logic [4:0] op);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, op[i]);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = 32'h0;
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i < 32) dout[i] = tdo;
      tck_cycle(i == n - 1, din[i % 32]);
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic tlr_to_rti();
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dout;
    logic [4:0]  ops [4];
    init_tbl();
    rst_n = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0; cap = 32'h0;
`ifdef JTAG_TAP_TRST_EN
    trst_n = 1'b1;
`endif
    repeat (4) @(negedge mclk);
    rst_n = 1'b1;
    repeat (4) @(negedge mclk);
    model_reset();
    kick();

    // 1: reset walk to Run-Test/Idle
    tlr_to_rti();
    chk("t1_state", 32'(tap_state), 32'hC);
    chk("t1_oe",    32'(tdo_oe),    32'h0);

    // 2: IDCODE selected after reset
    dr_scan(32, 32'h0, dout);
    chk("t2_idcode", dout, 32'hDEB1_1001);

    // 3: BYPASS gives one-bit delay, no strobe
    ir_scan(5'h1F);
    dr_scan(8, 32'h0000_00A5, dout);
    chk("t3_bypass", {24'h0, dout[7:0]}, 32'h0000_004A);
    chk("t3_nostb",  32'(stb_edges),     32'h0);

    // 4: USER capture and update
    cap = 32'h1234_5678;
    ir_scan(5'h10);
    dr_scan(32, 32'hCAFE_F00D, dout);
    chk("t4_cap",   dout,            32'h1234_5678);
    chk("t4_upd",   upd,             32'hCAFE_F00D);
    chk("t4_stb",   32'(stb_edges),  32'h1);

`ifdef JTAG_TAP_TRST_EN
    // 6: trst in Pause-DR keeps the user update value
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tck_cycle(1'b0, 1'b1);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    @(negedge mclk);
    trst_n = 1'b0;
    repeat (8) @(negedge mclk);
    trst_n = 1'b1;
    repeat (6) @(negedge mclk);
    m_state = TAP_TLR;
    m_ir    = 1;
    kick();
    chk("t6_state", 32'(tap_state), 32'hF);
    chk("t6_upd",   upd,            32'hCAFE_F00D);
    tck_cycle(1'b0, 1'b0);
    dr_scan(32, 32'h0, dout);
    chk("t6_idcode", dout, 32'hDEB1_1001);
`endif

    // 5: reset_n mid USER scan discards the partial data
    ir_scan(5'h10);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tck_cycle(1'b0, 1'($urandom_range(0, 1)));
    @(negedge mclk);
    rst_n = 1'b0;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    repeat (3) @(negedge mclk);
    model_reset();
    kick();
    chk("t5_state", 32'(tap_state), 32'hF);
    chk("t5_tdo",   32'(tdo),       32'h0);
    chk("t5_upd",   upd,            32'h0);
    chk("t5_stb",   32'(stb_edges), 32'h1);

    // Randomised sequences against the model
    ops[0] = 5'h01; ops[1] = 5'h10; ops[2] = 5'h1F; ops[3] = 5'h00;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: tlr_to_rti();
        1: begin
          ops[3] = 5'($urandom_range(0, 31));
          ir_scan(ops[$urandom_range(0, 3)]);
        end
        2: begin
          cap = $urandom;
          dr_scan($urandom_range(1, 40), $urandom, dout);
        end
        default: begin
          for (int j = 0; j < 20; j++)
            tck_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
